lcc_packet_parser: RTL
======================

# lcc_packet_parser

Byte-level packet parser between the LCC UART receiver and the SKUT frame former. It takes the 8-bit byte/valid stream produced by the LCC RX UART and hunts for sync. It collects a fixed-length packet, verifies its XOR checksum, and then emits two things:
- the 6-bit fast-channel sample, used as the former's fast data/valid input;
- a burst of slow-channel bytes on a write port into a small slow-parameter store.

It also supervises the link: inter-byte timeout, sequence-gap detection and a saturating error counter.

## Interface
Parameters:
- SYNC, 8'hA5, packet start byte
- PAYLOAD, 4, payload bytes per packet (2..8); byte 0 is fast, bytes 1..PAYLOAD-1 are slow
- TIMEOUT, 16'd4000, max clk cycles allowed between bytes inside a packet

Ports:
- clk  input  1  system clock (clk80 domain)
- reset  input  1  synchronous, active-high
- iData  input  8  received byte
- iVal  input  1  one-cycle strobe, iData valid
- oFastData  output  6  fast sample = payload byte 0 [5:0], held until next good packet
- oFastVal  output  1  one-cycle strobe, new oFastData
- oSlowData  output  8  slow byte
- oSlowAddr  output  3  slow byte index, 0..PAYLOAD-2
- oSlowWr  output  1  write strobe for oSlowData/oSlowAddr
- oSeqMiss  output  1  one-cycle strobe, good packet whose CNT is not last CNT+1
- oErrCnt  output  8  saturating count of checksum and timeout errors
- oLinkOk  output  1  high after a good packet, low after an error or reset

## Operation
Packet format: SYNC, CNT, P0..P(PAYLOAD-1), CHK. CHK = CNT ^ P0 ^ ... ^ P(PAYLOAD-1).

States:
- HUNT: on iVal with iData==SYNC → SEQ; any other byte is ignored and not counted.
- SEQ: on iVal, latch CNT, init running xor = iData, byte index = 0 → PAY.
- PAY: on iVal, store byte[index], xor ^= iData, index++; on the last payload byte → CHK.
- CHK: on iVal, if iData==xor → EMIT, else oErrCnt++, oLinkOk=0 → HUNT.
- EMIT: lasts PAYLOAD-1 cycles, k = 0..PAYLOAD-2; each cycle drives oSlowWr=1, oSlowAddr=k, oSlowData=byte[k+1].
  - First EMIT cycle also: oFastData=byte[0][5:0], oFastVal=1, oLinkOk=1, oSeqMiss per rule below; last CNT updated.
  - After the last cycle → HUNT.
  - iVal arriving during EMIT is dropped.

Timeout:
- A 16-bit gap counter clears on every iVal and increments otherwise.
- In SEQ, PAY or CHK, when the counter reaches TIMEOUT: → HUNT, oErrCnt++, oLinkOk=0, partial packet discarded.
- The counter is idle in HUNT and EMIT.

Sequence:
- The first good packet after reset only seeds last CNT; no oSeqMiss.
- Afterwards oSeqMiss=1 when CNT != (last+1) mod 256, including repeats.
- The packet is still emitted.

Error counter:
- oErrCnt saturates at 8'hFF.
- If a checksum error and a timeout fall in the same cycle, it increments by one only.
- SYNC bytes inside the payload are data; there is no resync mid-packet except via timeout or a bad checksum.

## Timing
- Reset (synchronous, sampled on clk): state HUNT, all strobes 0, oFastData=0, oSlowData=0, oSlowAddr=0, oErrCnt=0, oLinkOk=0, gap counter 0, sequence unseeded.
- Reset asserted mid-packet or mid-EMIT: abort at the next edge; no further strobes.
- All outputs are registered.
- First EMIT cycle (oFastVal and first oSlowWr) is the cycle after the clk edge that samples the CHK byte's iVal.
- oSlowWr is high for exactly PAYLOAD-1 consecutive cycles.
- oFastVal, oSeqMiss and oLinkOk change only in the first EMIT cycle, except oLinkOk falling on an error.
- Error updates (oErrCnt, oLinkOk) appear one cycle after the error-detecting edge.
- iVal is assumed at most once per 2 cycles (UART rate); back-to-back iVal in SEQ/PAY/CHK must still be accepted.

## Test plan
- Send A5,01,2A,10,20,30,2B with ~800-cycle gaps → one oFastVal with oFastData=6'h2A; oSlowWr for 3 cycles carrying addr/data 0/10, 1/20, 2/30; oLinkOk=1; oSeqMiss=0; oErrCnt=0.
- Same packet with CHK=2C → no oFastVal, no oSlowWr; oErrCnt=1; oLinkOk=0; the next good packet is accepted normally.
- Send packets with CNT=01 then CNT=03 (checksums correct) → both emitted; oSeqMiss strobes once, on the second packet only.
- Send A5,01,2A, then idle for 4001 cycles, then a full good packet → oErrCnt=1 after the timeout; the following packet is emitted correctly.
- Send garbage 00,FF,5A before a good packet, plus a payload containing A5 (correct checksum) → garbage is ignored with no error; the A5 in the payload is treated as data.
- Send 300 bad-checksum packets → oErrCnt holds at FF; then assert reset during a PAY state → all outputs at reset values and no strobes until the next full packet.

Source files
------------

// File: rtl/lcc_packet_parser.sv
// LCC byte-stream packet parser: sync hunt, XOR-checked fixed-length packets,
// fast-sample/slow-byte emission and link supervision (timeout, sequence, errors).
module lcc_packet_parser #(
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int unsigned PAYLOAD = 4,
    parameter logic [15:0] TIMEOUT = 16'd4000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] iData,
    input  logic       iVal,
    output logic [5:0] oFastData,
    output logic       oFastVal,
    output logic [7:0] oSlowData,
    output logic [2:0] oSlowAddr,
    output logic       oSlowWr,
    output logic       oSeqMiss,
    output logic [7:0] oErrCnt,
    output logic       oLinkOk
);

    typedef enum logic [2:0] {HUNT, SEQ, PAY, CHK, EMIT} state_t;

    localparam logic [2:0] LAST_IDX = 3'(PAYLOAD - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  xor_q, xor_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  pbuf_q [8];
    logic [7:0]  pbuf_d [8];
    logic [15:0] gap_q, gap_d;
    logic [7:0]  last_cnt_q, last_cnt_d;
    logic        seeded_q, seeded_d;
    logic [5:0]  fast_data_q, fast_data_d;
    logic        fast_val_q, fast_val_d;
    logic [7:0]  slow_data_q, slow_data_d;
    logic [2:0]  slow_addr_q, slow_addr_d;
    logic        slow_wr_q, slow_wr_d;
    logic        seq_miss_q, seq_miss_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        link_ok_q, link_ok_d;

    logic        active, timeout, err;
    logic [2:0]  idx_next;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        xor_d       = xor_q;
        idx_d       = idx_q;
        pbuf_d      = pbuf_q;
        last_cnt_d  = last_cnt_q;
        seeded_d    = seeded_q;
        fast_data_d = fast_data_q;
        slow_data_d = slow_data_q;
        slow_addr_d = slow_addr_q;
        err_cnt_d   = err_cnt_q;
        link_ok_d   = link_ok_q;
        fast_val_d  = 1'b0;
        slow_wr_d   = 1'b0;
        seq_miss_d  = 1'b0;
        err         = 1'b0;
        idx_next    = idx_q + 3'd1;

        active  = (state_q == SEQ) || (state_q == PAY) || (state_q == CHK);
        timeout = active && (gap_q == TIMEOUT);
        gap_d   = (active && !iVal) ? gap_q + 16'd1 : '0;

        // Timeout wins over a byte arriving on the same edge.
        case (state_q)
            HUNT: begin
                if (iVal && iData == SYNC) state_d = SEQ;
            end
            SEQ: begin
                if (timeout) begin
                    err = 1'b1;
                end else if (iVal) begin
                    cnt_d   = iData;
                    xor_d   = iData;
                    idx_d   = '0;
                    state_d = PAY;
                end
            end
            PAY: begin
                if (timeout) begin
                    err = 1'b1;
                end else if (iVal) begin
                    pbuf_d[idx_q] = iData;
                    xor_d         = xor_q ^ iData;
                    idx_d         = idx_next;
                    if (idx_q == LAST_IDX) state_d = CHK;
                end
            end
            CHK: begin
                if (timeout) begin
                    err = 1'b1;
                end else if (iVal) begin
                    if (iData == xor_q) begin
                        fast_val_d  = 1'b1;
                        fast_data_d = pbuf_q[0][5:0];
                        link_ok_d   = 1'b1;
                        seq_miss_d  = seeded_q && (cnt_q != last_cnt_q + 8'd1);
                        last_cnt_d  = cnt_q;
                        seeded_d    = 1'b1;
                        slow_wr_d   = 1'b1;
                        slow_addr_d = '0;
                        slow_data_d = pbuf_q[1];
                        idx_d       = 3'd1;
                        state_d     = EMIT;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            EMIT: begin
                // idx_q is the next slow address; the first one went out on entry.
                if (idx_q == LAST_IDX) begin
                    state_d = HUNT;
                end else begin
                    slow_wr_d   = 1'b1;
                    slow_addr_d = idx_q;
                    slow_data_d = pbuf_q[idx_next];
                    idx_d       = idx_next;
                end
            end
            default: state_d = HUNT;
        endcase

        if (err) begin
            state_d   = HUNT;
            link_ok_d = 1'b0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            cnt_q       <= '0;
            xor_q       <= '0;
            idx_q       <= '0;
            pbuf_q      <= '{default: '0};
            gap_q       <= '0;
            last_cnt_q  <= '0;
            seeded_q    <= 1'b0;
            fast_data_q <= '0;
            fast_val_q  <= 1'b0;
            slow_data_q <= '0;
            slow_addr_q <= '0;
            slow_wr_q   <= 1'b0;
            seq_miss_q  <= 1'b0;
            err_cnt_q   <= '0;
            link_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            xor_q       <= xor_d;
            idx_q       <= idx_d;
            pbuf_q      <= pbuf_d;
            gap_q       <= gap_d;
            last_cnt_q  <= last_cnt_d;
            seeded_q    <= seeded_d;
            fast_data_q <= fast_data_d;
            fast_val_q  <= fast_val_d;
            slow_data_q <= slow_data_d;
            slow_addr_q <= slow_addr_d;
            slow_wr_q   <= slow_wr_d;
            seq_miss_q  <= seq_miss_d;
            err_cnt_q   <= err_cnt_d;
            link_ok_q   <= link_ok_d;
        end
    end

    assign oFastData = fast_data_q;
    assign oFastVal  = fast_val_q;
    assign oSlowData = slow_data_q;
    assign oSlowAddr = slow_addr_q;
    assign oSlowWr   = slow_wr_q;
    assign oSeqMiss  = seq_miss_q;
    assign oErrCnt   = err_cnt_q;
    assign oLinkOk   = link_ok_q;

endmodule
